// File: rtl/fir_coeff_pkg.sv
// Shared defaults and FSM state encoding for the FIR coefficient loader.
package fir_coeff_pkg;

  localparam int CBITS_DEF = 18;
  localparam int NTAPS_DEF = 5;
  localparam int FLUSH_CW  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/fir_flush_counter.sv
// Loadable down-counter that times the downstream filter flush.
module fir_flush_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         term_o
);

  logic [W-1:0] cnt_reg;

  // Reset preloads the full length so the post-reset flush is timed from release.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || load_i) begin
      cnt_reg <= load_val_i;
    end else if (en_i && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign term_o = en_i && (cnt_reg == W'(1));

endmodule

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader with flush sequencing.
// Optional readback port enabled by defining FIR_COEFF_READBACK_EN.
module fir_coeff_loader
  import fir_coeff_pkg::*;
#(
  parameter int NTAPS     = NTAPS_DEF,
  parameter int CBITS     = CBITS_DEF,
  parameter int FLUSH_LEN = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [CBITS-1:0]       coeff_dat_i,
  input  logic                   coeff_valid_i,
  output logic                   coeff_ready_o,
  input  logic                   commit_i,
  input  logic                   err_clr_i,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [2:0]             rb_addr_i,
  output logic [CBITS-1:0]       rb_dat_o,
`endif
  output logic [NTAPS*CBITS-1:0] coeff_o,
  output logic                   dsp_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

  state_t state_reg, state_next;
  logic [IDXW-1:0] idx_reg;
  logic [CBITS-1:0] shadow_reg [NTAPS];
  logic [CBITS-1:0] active_reg [NTAPS];

  logic ready_reg, ready_next;
  logic dsp_rst_reg, dsp_rst_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic err_reg, err_next;

  logic accept, last_word, commit_ok, commit_bad, flush_expire;

  assign accept     = coeff_valid_i && ready_reg;
  assign last_word  = accept && (idx_reg == LAST_IDX);
  assign commit_ok  = commit_i && (state_reg == FULL);
  assign commit_bad = commit_i && (state_reg != FULL);

  fir_flush_counter #(.W(FLUSH_CW)) u_flush (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (commit_ok),
    .load_val_i (FLUSH_CW'(FLUSH_LEN)),
    .en_i       (state_reg == FLUSH),
    .term_o     (flush_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_reg <= FLUSH;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = last_word ? FULL : LOAD;
      LOAD:    if (last_word) state_next = FULL;
      FULL:    if (commit_i) state_next = FLUSH;
      FLUSH:   if (flush_expire) state_next = EMPTY;
      default: state_next = FLUSH;
    endcase
  end

  // Outputs are derived from the upcoming state so they register in step with it.
  always_comb begin
    ready_next   = (state_next == EMPTY) || (state_next == LOAD);
    dsp_rst_next = (state_next == FLUSH);
    busy_next    = (state_next == FLUSH);
    done_next    = (state_reg == FLUSH) && (state_next == EMPTY);
    err_next     = err_reg;
    if (commit_bad)     err_next = 1'b1;
    else if (err_clr_i) err_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ready_reg   <= 1'b0;
      dsp_rst_reg <= 1'b1;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      ready_reg   <= ready_next;
      dsp_rst_reg <= dsp_rst_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)        idx_reg <= '0;
    else if (last_word) idx_reg <= '0;
    else if (accept)    idx_reg <= idx_reg + IDXW'(1);
  end

  // Shadow and active banks are separate so a commit swaps all taps at once.
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      always_ff @(posedge clk_i) begin
        if (!rstn_i)                                shadow_reg[gi] <= '0;
        else if (accept && idx_reg == IDXW'(gi))    shadow_reg[gi] <= coeff_dat_i;
      end

      always_ff @(posedge clk_i) begin
        if (!rstn_i)        active_reg[gi] <= '0;
        else if (commit_ok) active_reg[gi] <= shadow_reg[gi];
      end

      assign coeff_o[gi*CBITS +: CBITS] = active_reg[gi];
    end
  endgenerate

`ifdef FIR_COEFF_READBACK_EN
  logic [CBITS-1:0] rb_sel;
  logic [CBITS-1:0] rb_dat_reg;

  always_comb begin
    rb_sel = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (k < 8 && rb_addr_i == 3'(k)) rb_sel = active_reg[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) rb_dat_reg <= '0;
    else         rb_dat_reg <= rb_sel;
  end

  assign rb_dat_o = rb_dat_reg;
`endif

  assign coeff_ready_o = ready_reg;
  assign dsp_rst_o     = dsp_rst_reg;
  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign err_o         = err_reg;

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter NTAPS, default 5: number of coefficients held, one per filter DSP.
REQ-002 Parameter CBITS, default 18: coefficient width, matching the DSP B port.
REQ-003 Parameter FLUSH_LEN, default 8, range 1..255: cycles the downstream filter is held in reset after a commit.
REQ-004 clk_i  input  1: filter clock; one clock.
REQ-005 rstn_i  input  1: reset, synchronous, active-low.
REQ-006 coeff_dat_i  input  CBITS: coefficient word, tap 0 first.
REQ-007 coeff_valid_i  input  1: coeff_dat_i valid.
REQ-008 coeff_ready_o  output  1: loader accepts a word this cycle.
REQ-009 commit_i  input  1: single-cycle request to apply the shadow set.
REQ-010 err_clr_i  input  1: clears err_o.
REQ-011 coeff_o  output  NTAPS*CBITS: active coefficients, tap k at bits [k*CBITS +: CBITS].
REQ-012 dsp_rst_o  output  1: active-high reset to the filter DSPs.
REQ-013 busy_o  output  1: flush in progress.
REQ-014 done_o  output  1: one-cycle pulse when an update completes.
REQ-015 err_o  output  1: sticky error flag.

Function
REQ-016 FSM states: EMPTY, LOAD, FULL, FLUSH; all outputs registered.
REQ-017 A word is accepted when coeff_valid_i && coeff_ready_o; it is written to shadow[idx] and idx increments.
REQ-018 coeff_ready_o is 1 exactly in EMPTY and LOAD.
REQ-019 EMPTY->LOAD on the first accepted word; LOAD->FULL on the word written to idx NTAPS-1; idx returns to 0.
REQ-020 In FULL, coeff_ready_o is 0; words presented are held off, not dropped.
REQ-021 commit_i in FULL at cycle N: coeff_o takes the shadow set at N+1; dsp_rst_o and busy_o are 1 for cycles N+1..N+FLUSH_LEN; state is FLUSH.
REQ-022 FLUSH->EMPTY after FLUSH_LEN cycles; done_o pulses at N+FLUSH_LEN+1 with dsp_rst_o and busy_o 0.
REQ-023 commit_i in EMPTY or LOAD, including the cycle the last word is accepted, is ignored and sets err_o; shadow contents and idx are unchanged.
REQ-024 commit_i in FLUSH is ignored and sets err_o.
REQ-025 err_o clears on err_clr_i; a simultaneous set has priority over the clear.
REQ-026 coeff_o changes only on an accepted commit and is never partially updated.

Reset
REQ-027 While rstn_i=0: coeff_o=0, shadow=0, idx=0, err_o=0, done_o=0, coeff_ready_o=0, dsp_rst_o=1, busy_o=1.
REQ-028 On release, state is FLUSH with a full FLUSH_LEN count; done_o pulses at the end.
REQ-029 Reset mid-load discards the partial shadow set; reset mid-flush restarts the flush count.

Configuration
REQ-030 Macro FIR_COEFF_READBACK_EN, when defined, adds rb_addr_i (input, 3 bits) and rb_dat_o (output, CBITS); rb_dat_o is the active coefficient at rb_addr_i, registered, latency 1, 0 for addresses >= NTAPS, and 0 in reset.
REQ-031 Without FIR_COEFF_READBACK_EN, those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-032 Package fir_coeff_pkg holds the CBITS default (18), the NTAPS default (5) and the FSM state enum.
REQ-033 Sub-module fir_flush_counter (load, count-down, terminal pulse) implements the FLUSH timer.
REQ-034 The index counter width is $clog2(NTAPS).

Verification
REQ-035 After reset, load 1,2,3,4,5 with no gaps, then commit -> coeff_o={5,4,3,2,1} one cycle after commit, dsp_rst_o high for 8 cycles, done_o pulse on cycle 9.
REQ-036 Hold coeff_valid_i high with 7 words -> exactly 5 accepted; ready goes low in FULL; word 6 is accepted only after done_o.
REQ-037 Commit after 3 words -> err_o=1 and coeff_o unchanged; load 2 more words and commit -> update proceeds; err_clr_i -> err_o=0.
REQ-038 Commit during FLUSH -> err_o=1 and flush length unchanged at 8; commit on the cycle the 5th word is accepted -> err_o=1 and state FULL.
REQ-039 Assert rstn_i=0 for one cycle after 2 words -> coeff_o=0, flush restarts, and the next load starts at tap 0.
REQ-040 With FIR_COEFF_READBACK_EN, rb_addr_i=2 after commit -> rb_dat_o=3 one cycle later; rb_addr_i=6 -> 0.
